normalizer: RTL and testbench
=============================

// Module: normalizer
// PURPOSE
//   Multi-cycle normalizer: the inverse of the barrel shifter. It finds how
//   far an operand must be shifted left to remove its redundant leading bits,
//   and returns the shifted value together with that amount.
//   Unsigned mode removes leading zeros. Signed mode removes leading bits that
//   are copies of the sign bit.
//   The block sits beside the shifter in the datapath and feeds CLZ/CLS and
//   normalize results back to the register file through a valid/ready
//   handshake.
// PARAMETERS
//   WIDTH  18                   operand width in bits
//   STEP   4                    max 1-bit shifts applied per BUSY cycle (1..WIDTH)
//   SW     $clog2(WIDTH+1) = 5  shift-count width (derived; do not override)
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      reset, asynchronous, active-high
//   in_valid   in   1      operand offered
//   in_ready   out  1      block can accept an operand
//   in_data    in   WIDTH  operand
//   in_signed  in   1      1 = signed (CLS), 0 = unsigned (CLZ)
//   out_valid  out  1      result available
//   out_ready  in   1      consumer takes the result
//   out_data   out  WIDTH  normalized value
//   out_shamt  out  SW     number of positions shifted left
//   out_zero   out  1      captured operand was all zeros
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE; in_ready=1; out_valid=0;
//   out_data=0, out_shamt=0, out_zero=0. Reset mid-BUSY/DONE discards the
//   operation; no result is produced.
// - FSM states: IDLE, BUSY, DONE.
//   - IDLE: in_ready=1. On in_valid: capture data/mode, shamt=0,
//     out_zero=(in_data==0), then go to BUSY.
//   - BUSY: in_ready=0, out_valid=0. Apply up to STEP one-bit left shifts
//     (combinational unroll). Each shift is applied only if the current
//     value is redundant:
//     - unsigned: redundant = (d[W-1]==0) && (shamt<WIDTH)
//     - signed:   redundant = (d[W-1]==d[W-2]) && (shamt<WIDTH-1)
//     Each applied shift does d <= d<<1 (zero fill) and shamt+1.
//     If the stop condition holds after this cycle's shifts, go to DONE;
//     otherwise stay in BUSY.
//   - DONE: out_valid=1. out_data, out_shamt and out_zero are held stable
//     while out_ready=0. On out_ready go to IDLE; in_ready rises the next
//     cycle. There is no accept-in-DONE bypass.
// - Latency: the accept edge enters BUSY. B = max(1, ceil(shamt/STEP)) BUSY
//   cycles follow. out_valid is high B edges after the accept edge.
//   Worst case with the defaults is B=5.
// - Limits:
//   - unsigned zero: shamt=WIDTH, out_data=0.
//   - signed 0 or all-ones: shamt=WIDTH-1.
//   - already normalized: shamt=0, B=1.
//   - shamt never exceeds WIDTH; no wrap.
// - Invariant: (out_data >> out_shamt) == in_data. Use a logical shift in
//   unsigned mode and an arithmetic shift in signed mode. The unsigned-zero
//   case is excluded.
// - in_valid while in_ready=0 is ignored; the operand is not captured.
// TESTING (WIDTH=18, STEP=4)
// 1. unsigned 18'h00001 -> out_data 18'h20000, shamt 17, zero 0; out_valid
//    5 edges after accept.
// 2. unsigned 18'h00000 -> out_data 0, shamt 18, zero 1, B=5.
//    signed 18'h00000 -> shamt 17, zero 1.
// 3. signed 18'h3FFFF -> out_data 18'h20000, shamt 17, B=5.
//    signed 18'h00100 -> out_data 18'h10000, shamt 8, B=2.
// 4. unsigned 18'h20000 and signed 18'h1FFFF -> shamt 0, data unchanged,
//    out_valid 1 edge after accept.
// 5. out_ready held 0 for 3 cycles in DONE -> outputs stable, in_ready=0.
//    An in_valid pulse in that window is not captured. After out_ready:
//    IDLE, in_ready=1.
// 6. Assert rst in the 2nd BUSY cycle of test 1 -> outputs go to reset values
//    immediately. The next operand (18'h00010 unsigned) gives shamt 13,
//    data 18'h20000.
//    Also: random operands in both modes, with the shifter-inverse invariant
//    checked on each.

Source files
------------

// File: rtl/normalizer.sv
// Multi-cycle normalizer: shifts an operand left until its redundant leading bits
// (zeros, or copies of the sign) are gone, and reports how far it was shifted.
module normalizer #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned STEP  = 4,
    localparam int unsigned SW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SW-1:0]    out_shamt,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               sgn;
    logic               sgn_nxt;
    logic [WIDTH-1:0]   data_nxt;
    logic [SW-1:0]      shamt_nxt;
    logic               zero_nxt;
    logic [WIDTH-1:0]   step_data;
    logic [SW-1:0]      step_shamt;

    // A shift is legal only while the top bit carries no information.
    function automatic logic redundant(input logic [WIDTH-1:0] v,
                                       input logic [SW-1:0]    s,
                                       input logic             sg);
        if (sg) begin
            return (v[WIDTH-1] == v[WIDTH-2]) && (s < SW'(WIDTH - 1));
        end
        return !v[WIDTH-1] && (s < SW'(WIDTH));
    endfunction

    // Up to STEP conditional one-bit shifts per BUSY cycle.
    always_comb begin
        step_data  = out_data;
        step_shamt = out_shamt;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (redundant(step_data, step_shamt, sgn)) begin
                step_data  = step_data << 1;
                step_shamt = step_shamt + SW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        sgn_nxt   = sgn;
        data_nxt  = out_data;
        shamt_nxt = out_shamt;
        zero_nxt  = out_zero;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    data_nxt  = in_data;
                    shamt_nxt = '0;
                    zero_nxt  = (in_data == '0);
                    sgn_nxt   = in_signed;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                data_nxt  = step_data;
                shamt_nxt = step_shamt;
                if (!redundant(step_data, step_shamt, sgn)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they track it exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sgn       <= 1'b0;
            out_data  <= '0;
            out_shamt <= '0;
            out_zero  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            sgn       <= sgn_nxt;
            out_data  <= data_nxt;
            out_shamt <= shamt_nxt;
            out_zero  <= zero_nxt;
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_normalizer.sv
// Testbench for normalizer: directed corner cases plus random operands against a
// leading-bit-count reference model.
module tb_normalizer;

    localparam int unsigned WIDTH = 18;
    localparam int unsigned STEP  = 4;
    localparam int unsigned SW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [SW-1:0]    out_shamt;
    logic             out_zero;

    int nvec = 0;
    int nerr = 0;

    normalizer #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shamt (out_shamt),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: count redundant leading bits by scanning from the top.
    function automatic int ref_shamt(input logic [WIDTH-1:0] x, input logic sg);
        if (!sg) begin
            for (int i = WIDTH - 1; i >= 0; i--) if (x[i]) return WIDTH - 1 - i;
            return WIDTH;
        end
        for (int i = WIDTH - 2; i >= 0; i--) if (x[i] != x[WIDTH-1]) return WIDTH - 2 - i;
        return WIDTH - 1;
    endfunction

    task automatic run(input logic [WIDTH-1:0] x, input logic sg, input int hold,
                       input string tag);
        int sh;
        int lat;
        int edges;
        logic [WIDTH-1:0] ed;
        logic [WIDTH-1:0] back;
        sh  = ref_shamt(x, sg);
        ed  = x << sh;
        lat = (sh == 0) ? 1 : (sh + STEP - 1) / STEP;
        edges = 0;
        while (!in_ready && edges < 50) begin
            @(posedge clk); #1; edges++;
        end
        chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data   = x;
        in_signed = sg;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        in_signed = 1'($urandom);
        chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        edges = 0;
        do begin
            @(posedge clk); #1; edges++;
        end while (!out_valid && edges < 40);
        chk({tag, ".latency"}, 32'(edges), 32'(lat));
        chk({tag, ".data"}, 32'(out_data), 32'(ed));
        chk({tag, ".shamt"}, 32'(out_shamt), 32'(sh));
        chk({tag, ".zero"}, 32'(out_zero), 32'(x == '0));
        if (!(x == '0 && !sg)) begin
            if (sg) back = WIDTH'($signed(out_data) >>> out_shamt);
            else    back = out_data >> out_shamt;
            chk({tag, ".inverse"}, 32'(back), 32'(x));
        end
        for (int h = 0; h < hold; h++) begin
            if (h == 0) begin
                in_valid = 1'b1;
                in_data  = ~x;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_data"}, 32'(out_data), 32'(ed));
            chk({tag, ".hold_shamt"}, 32'(out_shamt), 32'(sh));
            chk({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".drain_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".drain_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] x;
        logic             sg;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.out_data", 32'(out_data), 32'd0);
        chk("reset.out_shamt", 32'(out_shamt), 32'd0);
        chk("reset.out_zero", 32'(out_zero), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run(18'h00001, 1'b0, 0, "u_one");
        run(18'h00000, 1'b0, 0, "u_zero");
        run(18'h00000, 1'b1, 0, "s_zero");
        run(18'h3FFFF, 1'b1, 0, "s_ones");
        run(18'h00100, 1'b1, 0, "s_0100");
        run(18'h20000, 1'b0, 0, "u_norm");
        run(18'h1FFFF, 1'b1, 0, "s_norm");

        // Back-pressure: the in_valid pulse while DONE must not be captured.
        run(18'h00C00, 1'b0, 3, "hold");
        repeat (3) begin
            @(posedge clk); #1;
            chk("hold.no_capture", 32'(out_valid), 32'd0);
        end

        // Reset during the second BUSY cycle.
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 18'h00001;
        in_signed = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.in_ready", 32'(in_ready), 32'd1);
        chk("midrst.out_data", 32'(out_data), 32'd0);
        chk("midrst.out_shamt", 32'(out_shamt), 32'd0);
        chk("midrst.out_zero", 32'(out_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(18'h00010, 1'b0, 0, "after_rst");

        for (int n = 0; n < 60; n++) begin
            x  = WIDTH'($urandom) >> $urandom_range(0, WIDTH);
            sg = 1'($urandom);
            if (sg && $urandom_range(0, 1) == 1) x = ~x;
            if ($urandom_range(0, 15) == 0) x = '0;
            run(x, sg, $urandom_range(0, 2), $sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
